// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and next-PC select codes for the fetch-stage program counter
package pc_pkg;

    localparam int          PC_WIDTH             = 32;
    localparam int          PC_INC               = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_HOLD,
        SEL_INC
    } pc_sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - priority select of the next fetch address (reset > branch > jump > stall > pc+4)
// Optional PC_ALIGN_CHECK_EN adds the target_fault output for low-bit-set targets.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] next_pc,
`ifdef PC_ALIGN_CHECK_EN
    output logic             target_fault,
`endif
    output pc_sel_e          sel
);

    // Clearing the two low bits keeps every loaded address word-aligned.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~{{(WIDTH-2){1'b0}}, 2'b11};

    always_comb begin
        sel = SEL_INC;
        if (!reset) begin
            sel = SEL_RESET;
        end else if (branch_taken) begin
            sel = SEL_BRANCH;
        end else if (jump) begin
            sel = SEL_JUMP;
        end else if (stall) begin
            sel = SEL_HOLD;
        end
    end

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            SEL_RESET:  next_pc = RESET_VECTOR;
            SEL_BRANCH: next_pc = branch_target & ALIGN_MASK;
            SEL_JUMP:   next_pc = jump_target & ALIGN_MASK;
            SEL_HOLD:   next_pc = pc;
            default:    next_pc = pc_plus4;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    always_comb begin
        target_fault = 1'b0;
        if (sel == SEL_BRANCH) begin
            target_fault = |branch_target[1:0];
        end else if (sel == SEL_JUMP) begin
            target_fault = |jump_target[1:0];
        end
    end
`endif

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - MIPS fetch-stage PC register with combinational pc+4
// Define PC_ALIGN_CHECK_EN to add the registered misaligned-target flag.
module program_counter
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
`ifdef PC_ALIGN_CHECK_EN
    output logic             misaligned,
`endif
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4
);

    if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
        $error("program_counter: RESET_VECTOR must be word-aligned");
    end

    logic [WIDTH-1:0] next_pc;
    pc_sel_e          sel;
`ifdef PC_ALIGN_CHECK_EN
    logic             target_fault;
`endif

    pc_next_mux #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_next_mux (
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc),
`ifdef PC_ALIGN_CHECK_EN
        .target_fault  (target_fault),
`endif
        .sel           (sel)
    );

    // Wraps modulo 2^WIDTH by construction; no carry out is kept.
    assign pc_plus4 = pc + WIDTH'(PC_INC);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_VECTOR;
        end else if (sel != SEL_HOLD) begin
            pc <= next_pc;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= target_fault;
        end
    end
`endif

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - scoreboard bench for program_counter (misaligned checks under PC_ALIGN_CHECK_EN)
module tb_program_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    program_counter dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
`ifdef PC_ALIGN_CHECK_EN
        .misaligned    (misaligned),
`endif
        .pc            (pc),
        .pc_plus4      (pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        jump = 1'b0;
        jump_target = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e) begin errors++; $display("FAIL reset_pc got %h want %h", pc, e); end
        checks++;
        if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 got %h want %h", pc_plus4, 32'h4); end
`ifdef PC_ALIGN_CHECK_EN
        checks++;
        if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got %b want 0", misaligned); end
`endif
    endtask

    task automatic test_release();
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(32'(4 * k));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e) begin errors++; $display("FAIL release_pc edge %0d got %h want %h", k, pc, e); end
            checks++;
            if (pc_plus4 !== e + 32'h4) begin errors++; $display("FAIL release_pc_plus4 got %h want %h", pc_plus4, e + 32'h4); end
        end
    endtask

    task automatic test_midrun_reset();
        reset = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h500;
        jump = 1'b1;
        jump_target = 32'h600;
        exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e) begin errors++; $display("FAIL midrun_reset_pc got %h want %h", pc, e); end
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(32'(4 * k));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e) begin errors++; $display("FAIL midrun_release_pc got %h want %h", pc, e); end
        end
    endtask

    task automatic test_stall_redirect();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (pc !== 32'h8) begin errors++; $display("FAIL stall_setup_pc got %h want %h", pc, 32'h8); end
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(32'h8);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e) begin errors++; $display("FAIL stall_hold_pc got %h want %h", pc, e); end
            checks++;
            if (pc_plus4 !== 32'hC) begin errors++; $display("FAIL stall_pc_plus4 got %h want %h", pc_plus4, 32'hC); end
        end
        jump = 1'b1;
        jump_target = 32'h100;
        exp_q.push_back(32'h100);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e) begin errors++; $display("FAIL stall_jump_pc got %h want %h", pc, e); end
        checks++;
        if (pc_plus4 !== 32'h104) begin errors++; $display("FAIL stall_jump_pc_plus4 got %h want %h", pc_plus4, 32'h104); end
        idle_inputs();
    endtask

    task automatic test_priority();
        branch_taken = 1'b1;
        branch_target = 32'h200;
        jump = 1'b1;
        jump_target = 32'h300;
        stall = 1'b1;
        exp_q.push_back(32'h200);
        tick();
        idle_inputs();
        exp_q.push_back(32'h204);
        e = exp_q.pop_front();
        checks++;
        if (pc !== e) begin errors++; $display("FAIL priority_branch_pc got %h want %h", pc, e); end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e) begin errors++; $display("FAIL priority_after_pc got %h want %h", pc, e); end
        jump = 1'b1;
        jump_target = 32'h340;
        stall = 1'b1;
        exp_q.push_back(32'h340);
        tick();
        idle_inputs();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e) begin errors++; $display("FAIL priority_jump_over_stall got %h want %h", pc, e); end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        idle_inputs();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e) begin errors++; $display("FAIL wrap_top_pc got %h want %h", pc, e); end
        checks++;
        if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_top_pc_plus4 got %h want %h", pc_plus4, 32'h0); end
        exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e) begin errors++; $display("FAIL wrap_pc got %h want %h", pc, e); end
        checks++;
        if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL wrap_pc_plus4 got %h want %h", pc_plus4, 32'h4); end
    endtask

    task automatic test_alignment();
        jump = 1'b1;
        jump_target = 32'h103;
        exp_q.push_back(32'h100);
        tick();
        idle_inputs();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e) begin errors++; $display("FAIL align_jump_pc got %h want %h", pc, e); end
`ifdef PC_ALIGN_CHECK_EN
        checks++;
        if (misaligned !== 1'b1) begin errors++; $display("FAIL align_jump_flag got %b want 1", misaligned); end
`endif
        exp_q.push_back(32'h104);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e) begin errors++; $display("FAIL align_next_pc got %h want %h", pc, e); end
`ifdef PC_ALIGN_CHECK_EN
        checks++;
        if (misaligned !== 1'b0) begin errors++; $display("FAIL align_flag_clear got %b want 0", misaligned); end
`endif
        // Misaligned jump ignored because the aligned branch wins: no flag.
        branch_taken = 1'b1;
        branch_target = 32'h2000;
        jump = 1'b1;
        jump_target = 32'h3001;
        exp_q.push_back(32'h2000);
        tick();
        idle_inputs();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e) begin errors++; $display("FAIL align_branch_pc got %h want %h", pc, e); end
`ifdef PC_ALIGN_CHECK_EN
        checks++;
        if (misaligned !== 1'b0) begin errors++; $display("FAIL align_unselected_flag got %b want 0", misaligned); end
`endif
        branch_taken = 1'b1;
        branch_target = 32'h4002;
        exp_q.push_back(32'h4000);
        tick();
        idle_inputs();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e) begin errors++; $display("FAIL align_branch_low_pc got %h want %h", pc, e); end
`ifdef PC_ALIGN_CHECK_EN
        checks++;
        if (misaligned !== 1'b1) begin errors++; $display("FAIL align_branch_flag got %b want 1", misaligned); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (misaligned !== 1'b0) begin errors++; $display("FAIL align_reset_flag got %b want 0", misaligned); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt[4];
        logic [31:0] tsel;
        tgt[0] = 32'h40;
        tgt[1] = 32'h80;
        tgt[2] = 32'h1000;
        tgt[3] = 32'h7FFC;
        for (int i = 0; i < 4; i++) begin
            tsel = tgt[i];
            idle_inputs();
            if (i[0]) begin
                jump = 1'b1;
                jump_target = tsel;
            end else begin
                branch_taken = 1'b1;
                branch_target = tsel;
            end
            exp_q.push_back(tsel);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e) begin errors++; $display("FAIL back_to_back_pc %0d got %h want %h", i, pc, e); end
        end
        idle_inputs();
        exp_q.push_back(32'h8000);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e) begin errors++; $display("FAIL back_to_back_inc got %h want %h", pc, e); end
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_release();
        test_midrun_reset();
        test_stall_redirect();
        test_priority();
        test_wrap();
        test_alignment();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
